quantum_scheduler: RTL

- Round-robin process scheduler for the multitasking MIPS core.
- Consumes the decoded setQuantum, interruptionProcess and process-halt strobes plus an instruction-retire pulse.
- Counts each process's quantum and forces a trap to the OS handler on expiry or halt.
- Saves and restores per-process PCs so the OS change-context and get-address instructions can resume the next process.

---
 rtl/quantum_scheduler_pkg.sv | 16 +
 rtl/quantum_scheduler_if.sv | 46 ++++
 rtl/quantum_scheduler_rr_picker.sv | 29 ++
 rtl/quantum_scheduler.sv | 137 +++++++++++++
 4 files changed

// File: rtl/quantum_scheduler_pkg.sv
// Shared types and constants for the round-robin quantum scheduler.
// Halt codes mirror the control decoder's Halt field.
package quantum_scheduler_pkg;

    typedef enum logic [1:0] {
        ST_OS   = 2'd0,
        ST_RUN  = 2'd1,
        ST_TRAP = 2'd2
    } state_e;

    localparam logic [1:0] HALT_NONE = 2'b00;
    localparam logic [1:0] HALT_PROC = 2'b01;

    localparam int DEFAULT_QUANTUM = 100;

endpackage

// File: rtl/quantum_scheduler_if.sv
// Control/datapath bundle between the MIPS core and the scheduler.
// master is the core side, slave is the scheduler.
interface quantum_scheduler_if #(
    parameter int NUM_PROC  = 4,
    parameter int PID_W     = 2,
    parameter int PC_W      = 32,
    parameter int QUANTUM_W = 16
) ();

    logic                 set_quantum;
    logic [QUANTUM_W-1:0] quantum_value;
    logic                 ctx_switch;
    logic                 proc_halt;
    logic                 instr_retire;
    logic [PC_W-1:0]      pc_in;
    logic                 launch_valid;
    logic [PID_W-1:0]     launch_id;
    logic [PC_W-1:0]      launch_pc;
    logic                 preempt_ack;

    logic                 preempt_req;
    logic                 os_mode;
    logic [PID_W-1:0]     cur_pid;
    logic [PC_W-1:0]      next_pc;
    logic                 next_pc_valid;
    logic                 no_proc;
    logic [PC_W-1:0]      saved_addr;
    logic [NUM_PROC-1:0]  active_mask;

    modport master (
        output set_quantum, quantum_value, ctx_switch, proc_halt,
        output instr_retire, pc_in, launch_valid, launch_id,
        output launch_pc, preempt_ack,
        input  preempt_req, os_mode, cur_pid, next_pc,
        input  next_pc_valid, no_proc, saved_addr, active_mask
    );

    modport slave (
        input  set_quantum, quantum_value, ctx_switch, proc_halt,
        input  instr_retire, pc_in, launch_valid, launch_id,
        input  launch_pc, preempt_ack,
        output preempt_req, os_mode, cur_pid, next_pc,
        output next_pc_valid, no_proc, saved_addr, active_mask
    );

endinterface

// File: rtl/quantum_scheduler_rr_picker.sv
// Combinational round-robin selector: first active slot after start_i,
// wrapping around and ending at start_i itself.
module rr_picker #(
    parameter int NUM_PROC = 4,
    parameter int PID_W    = 2
) (
    input  logic [NUM_PROC-1:0] mask_i,
    input  logic [PID_W-1:0]    start_i,
    output logic                found_o,
    output logic [PID_W-1:0]    pid_o
);

    logic [PID_W-1:0] idx;

    // Walk from the farthest offset down so the nearest hit is written last.
    always_comb begin
        found_o = 1'b0;
        pid_o   = '0;
        idx     = '0;
        for (int i = NUM_PROC; i >= 1; i--) begin
            idx = start_i + PID_W'(i);
            if (mask_i[idx]) begin
                found_o = 1'b1;
                pid_o   = idx;
            end
        end
    end

endmodule

// File: rtl/quantum_scheduler.sv
// Round-robin quantum scheduler: counts retired instructions per process,
// traps to the OS on expiry or halt, and keeps per-process resume PCs.
module quantum_scheduler #(
    parameter int NUM_PROC        = 4,
    parameter int PID_W           = 2,
    parameter int PC_W            = 32,
    parameter int QUANTUM_W       = 16,
    parameter int DEFAULT_QUANTUM = 100
) (
    input logic                clock,
    input logic                reset_n,
    quantum_scheduler_if.slave bus
);

    import quantum_scheduler_pkg::*;

    state_e                         state_q, state_d;
    logic [QUANTUM_W-1:0]           quantum_q, quantum_d;
    logic [QUANTUM_W-1:0]           cnt_q, cnt_d;
    logic [PID_W-1:0]               pid_q, pid_d;
    logic [NUM_PROC-1:0]            active_q, active_d;
    logic [NUM_PROC-1:0][PC_W-1:0]  saved_q, saved_d;
    logic [PC_W-1:0]                npc_q, npc_d;
    logic                           npc_vld_q, npc_vld_d;
    logic                           noproc_q, noproc_d;

    logic                           launch_en;
    logic [NUM_PROC-1:0]            pick_mask;
    logic                           pick_found;
    logic [PID_W-1:0]               pick_pid;

    assign launch_en = (state_q == ST_OS) && bus.launch_valid;

    // A same-cycle launch must be visible to the picker.
    always_comb begin
        pick_mask = active_q;
        if (launch_en) pick_mask[bus.launch_id] = 1'b1;
    end

    rr_picker #(
        .NUM_PROC (NUM_PROC),
        .PID_W    (PID_W)
    ) u_picker (
        .mask_i  (pick_mask),
        .start_i (pid_q),
        .found_o (pick_found),
        .pid_o   (pick_pid)
    );

    always_comb begin
        state_d   = state_q;
        quantum_d = quantum_q;
        cnt_d     = cnt_q;
        pid_d     = pid_q;
        active_d  = active_q;
        saved_d   = saved_q;
        npc_d     = npc_q;
        npc_vld_d = 1'b0;
        noproc_d  = 1'b0;

        if (bus.set_quantum) begin
            quantum_d = (bus.quantum_value == '0) ? QUANTUM_W'(1)
                                                  : bus.quantum_value;
        end

        unique case (state_q)
            ST_OS: begin
                if (launch_en) begin
                    active_d                = pick_mask;
                    saved_d[bus.launch_id]  = bus.launch_pc;
                end
                if (bus.ctx_switch) begin
                    if (pick_found) begin
                        pid_d     = pick_pid;
                        npc_d     = saved_d[pick_pid];
                        npc_vld_d = 1'b1;
                        cnt_d     = quantum_q;
                        state_d   = ST_RUN;
                    end else begin
                        noproc_d  = 1'b1;
                    end
                end
            end
            ST_RUN: begin
                // Halt wins over a coincident expiry and saves nothing.
                if (bus.proc_halt) begin
                    active_d[pid_q] = 1'b0;
                    state_d         = ST_TRAP;
                end else if (bus.instr_retire) begin
                    cnt_d = cnt_q - QUANTUM_W'(1);
                    if (cnt_q == QUANTUM_W'(1)) begin
                        saved_d[pid_q] = bus.pc_in;
                        state_d        = ST_TRAP;
                    end
                end
            end
            ST_TRAP: begin
                if (bus.preempt_ack) state_d = ST_OS;
            end
            default: state_d = ST_OS;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= ST_OS;
            quantum_q <= QUANTUM_W'(DEFAULT_QUANTUM);
            cnt_q     <= '0;
            pid_q     <= '0;
            active_q  <= '0;
            saved_q   <= '0;
            npc_q     <= '0;
            npc_vld_q <= 1'b0;
            noproc_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            quantum_q <= quantum_d;
            cnt_q     <= cnt_d;
            pid_q     <= pid_d;
            active_q  <= active_d;
            saved_q   <= saved_d;
            npc_q     <= npc_d;
            npc_vld_q <= npc_vld_d;
            noproc_q  <= noproc_d;
        end
    end

    assign bus.preempt_req   = (state_q == ST_TRAP);
    assign bus.os_mode       = (state_q == ST_OS);
    assign bus.cur_pid       = pid_q;
    assign bus.next_pc       = npc_q;
    assign bus.next_pc_valid = npc_vld_q;
    assign bus.no_proc       = noproc_q;
    assign bus.saved_addr    = saved_q[pid_q];
    assign bus.active_mask   = active_q;

endmodule
